// File: rtl/fetch_unit_pkg.sv
// Shared types and sizing constants for the instruction fetch unit and its queue.
package fetch_unit_pkg;

  localparam int unsigned INSTRUCTION_QUEUE_DEPTH = 8;
  localparam int unsigned MAX_OUTSTANDING         = 4;

  typedef enum logic [1:0] {
    StFetch      = 2'd0,
    StCreditWait = 2'd1,
    StRedirect   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_credit_counter.sv
// Up/down credit counter with parallel load; refuses to step past 0 or MAX_COUNT.
module fetch_credit_counter
  import fetch_unit_pkg::*;
#(
  parameter int unsigned MAX_COUNT = INSTRUCTION_QUEUE_DEPTH,
  parameter int unsigned WIDTH     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_next = count_q;
    if (load) begin
      count_next = load_value;
    end else if (inc && !dec && count_q < MaxVal) begin
      count_next = count_q + 1'b1;
    end else if (dec && !inc && count_q != '0) begin
      count_next = count_q - 1'b1;
    end
  end

  // Starts full: every queue slot is free out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= MaxVal;
    end else begin
      count_q <= count_next;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential I-cache requests against queue credits and an
// in-flight limit, forwards responses to the queue, and drops stale ones after redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH     = fetch_unit_pkg::INSTRUCTION_QUEUE_DEPTH,
  parameter int unsigned MAX_OUTSTANDING = fetch_unit_pkg::MAX_OUTSTANDING
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ic_req_valid,
  input  logic        ic_req_ready,
  output logic [31:0] ic_req_pc,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_data,
  input  logic [31:0] ic_resp_pc,
  output logic        fq_valid,
  output logic [31:0] fq_data,
  output logic [31:0] fq_pc,
  input  logic        fq_pop,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  import fetch_unit_pkg::*;

  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] QDepth = CW'(QUEUE_DEPTH);
  localparam logic [OW-1:0] MaxOut = OW'(MAX_OUTSTANDING);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [CW-1:0] credits, credits_next;
  logic          req_ok, issue, resp_stale;

  // rst_n gates the strobes so they fall as soon as reset asserts.
  assign req_ok = rst_n && (state_q == StFetch) && (credits != '0) && (out_q < MaxOut)
                  && !redirect_valid;
  assign issue  = req_ok && ic_req_ready;

  assign ic_req_valid = req_ok;
  assign ic_req_pc    = pc_q;

  assign resp_stale = (drop_q != '0);
  assign fq_valid   = rst_n && ic_resp_valid && !resp_stale && !redirect_valid;
  assign fq_data    = ic_resp_data;
  assign fq_pc      = ic_resp_pc;

  fetch_credit_counter #(
    .MAX_COUNT (QUEUE_DEPTH),
    .WIDTH     (CW)
  ) u_credits (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (fq_pop && !redirect_valid),
    .dec        (issue),
    .load       (redirect_valid),
    .load_value (QDepth),
    .count      (credits),
    .count_next (credits_next)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;
    drop_d  = drop_q;

    if (issue) begin
      pc_d = pc_q + 32'd4;
    end

    unique case ({issue, ic_resp_valid})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   if (out_q != '0) out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    if (ic_resp_valid && resp_stale) begin
      drop_d = drop_q - 1'b1;
    end

    if (redirect_valid) begin
      // Everything still in flight (after this cycle's response) belongs to the old path.
      pc_d    = redirect_pc;
      drop_d  = out_d;
      state_d = StRedirect;
    end else begin
      case (state_q)
        StFetch: begin
          if (credits_next == '0 || out_d == MaxOut) state_d = StCreditWait;
        end
        StCreditWait: begin
          if (credits_next != '0 && out_d < MaxOut) state_d = StFetch;
        end
        StRedirect: state_d = StFetch;
        default:    state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter QUEUE_DEPTH, default 8, entries in the downstream instruction queue; power of two.
REQ-003 Parameter MAX_OUTSTANDING, default 4, maximum I-cache requests in flight; 1..15.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 ic_req_valid  out  1  fetch request to I-cache.
REQ-007 ic_req_ready  in  1  I-cache accepts request this cycle.
REQ-008 ic_req_pc  out  32  fetch address, word aligned.
REQ-009 ic_resp_valid  in  1  I-cache response, in request order, latency >= 1.
REQ-010 ic_resp_data  in  32  instruction word.
REQ-011 ic_resp_pc  in  32  address of ic_resp_data.
REQ-012 fq_valid  out  1  write strobe into instruction queue.
REQ-013 fq_data  out  32  instruction word to queue.
REQ-014 fq_pc  out  32  instruction address to queue.
REQ-015 fq_pop  in  1  queue dequeued one entry this cycle (queue valid and decode not stalled).
REQ-016 redirect_valid  in  1  branch/jump resolved mispredicted; queue flushes this same cycle.
REQ-017 redirect_pc  in  32  new fetch address.

Function
REQ-018 Counters: pc (32), credits (0..QUEUE_DEPTH), outstanding (0..MAX_OUTSTANDING), drop_cnt (0..MAX_OUTSTANDING).
REQ-019 States: FETCH, CREDIT_WAIT, REDIRECT.
REQ-020 ic_req_valid = 1 only in FETCH with credits > 0, outstanding < MAX_OUTSTANDING, redirect_valid = 0; ic_req_pc = pc.
REQ-021 Accepted request (ic_req_valid & ic_req_ready): pc += 4 (wraps mod 2^32), credits -= 1, outstanding += 1.
REQ-022 Response: outstanding -= 1; if drop_cnt > 0, drop_cnt -= 1 and fq_valid = 0 (stale); else fq_valid = 1 same cycle, fq_data/fq_pc = ic_resp_data/ic_resp_pc (combinational, zero latency).
REQ-023 fq_pop: credits += 1; simultaneous issue and pop leave credits unchanged.
REQ-024 Credits reserve queue slots, so fq_valid never asserts when the queue is full; credits never exceed QUEUE_DEPTH nor go below 0.
REQ-025 FETCH -> CREDIT_WAIT when next credits = 0 or next outstanding = MAX_OUTSTANDING; CREDIT_WAIT -> FETCH when both limits clear; ic_req_valid = 0 in CREDIT_WAIT.
REQ-026 redirect_valid in any state: pc <= redirect_pc, credits <= QUEUE_DEPTH, drop_cnt <= outstanding after this cycle's response decrement, no request issued, fq_valid forced 0, fq_pop ignored; next state REDIRECT.
REQ-027 REDIRECT lasts exactly one cycle, ic_req_valid = 0, then FETCH; first request at redirect_pc is presented two cycles after redirect_valid.
REQ-028 redirect_valid while in REDIRECT restarts REDIRECT with the newer redirect_pc.
REQ-029 Response and request accepted in same cycle: outstanding unchanged.

Reset
REQ-030 While rst_n = 0: pc = RESET_PC, credits = QUEUE_DEPTH, outstanding = 0, drop_cnt = 0, state FETCH, ic_req_valid = 0, fq_valid = 0.
REQ-031 Reset mid-operation discards in-flight requests; the I-cache is reset by the same rst_n so no stale responses follow.

Structure
REQ-032 Shared package holds fetch_state_t enum, INSTRUCTION_QUEUE_DEPTH and MAX_OUTSTANDING constants; the same depth constant sizes the instruction queue.
REQ-033 One sub-module, fetch_credit_counter (up/down saturating-checked counter with load), instantiated for credits.

Verification
REQ-034 Reset, RESET_PC=0, ready=1, 1-cycle cache, no pops -> requests at 0x0,0x4,...,0x1C, then CREDIT_WAIT, exactly 8 fq_valid pulses.
REQ-035 Continuing REQ-034, fq_pop for 3 cycles -> 3 further requests 0x20,0x24,0x28, credits return to 0.
REQ-036 ready=1, cache latency 10, MAX_OUTSTANDING=4 -> never more than 4 requests in flight; request rate 4 per 10 cycles.
REQ-037 4 outstanding, redirect_valid to 0x100 -> next 4 responses dropped (fq_valid=0), request 0x100 two cycles later, first fq_pc=0x100.
REQ-038 redirect_valid same cycle as response and fq_pop -> drop_cnt = outstanding-1, credits = QUEUE_DEPTH, no write to queue.
REQ-039 rst_n asserted mid-burst with pc=0x40 -> outputs low asynchronously; after release first request at RESET_PC.
